// File: rtl/set_job_issuer.sv
// Host-side job issuer for the SET coverage counter: one job in flight.
// Define SET_TIMEOUT_EN to abort a job after TIMEOUT cycles without SET valid.
module set_job_issuer #(
  parameter int TIMEOUT = 80,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [23:0]      job_central,
  input  logic [11:0]      job_radius,
  input  logic [1:0]       job_mode,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_cand,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_err,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  state_e           state_q;
  logic             en_q;
  logic [23:0]      central_q;
  logic [11:0]      radius_q;
  logic [1:0]       mode_q;
  logic             rvalid_q;
  logic [7:0]       rdata_q;
  logic [CNT_W-1:0] done_q;
  logic             accept;

`ifdef SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q;
  logic          err_q;
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  assign job_ready   = (state_q == IDLE) & ~set_busy;
  assign accept      = job_valid & job_ready;
  assign set_en      = en_q;
  assign set_central = central_q;
  assign set_radius  = radius_q;
  assign set_mode    = mode_q;
  assign res_valid   = rvalid_q;
  assign res_data    = rdata_q;
  assign done_cnt    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      done_q    <= '0;
`ifdef SET_TIMEOUT_EN
      timer_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            central_q <= job_central;
            radius_q  <= job_radius;
            mode_q    <= job_mode;
            en_q      <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef SET_TIMEOUT_EN
          timer_q <= '0;
`endif
        end
        WAIT: begin
          // A set_valid in the final timer cycle still wins.
          if (set_valid) begin
            rdata_q  <= set_cand;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
`ifdef SET_TIMEOUT_EN
            err_q    <= 1'b0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rdata_q  <= '0;
            err_q    <= 1'b1;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            timer_q  <= timer_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (res_ready) begin
            rvalid_q <= 1'b0;
            done_q   <= done_q + CNT_W'(1);
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_job_issuer.sv
// Bench for set_job_issuer: behavioural SET model, random jobs,
// scoreboard of expected results checked by an independent monitor.
module tb_set_job_issuer;

  localparam int TIMEOUT = 80;
  localparam int CNT_W   = 16;
  localparam int SET_LAT = 65;

  typedef struct {
    logic [7:0] d;
    bit         e;
    int         lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             job_valid;
  logic             job_ready;
  logic [23:0]      job_central;
  logic [11:0]      job_radius;
  logic [1:0]       job_mode;
  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_busy;
  logic             set_valid;
  logic [7:0]       set_cand;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_err;
  logic [CNT_W-1:0] done_cnt;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  int   rr_mode  = 2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  set_job_issuer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_central(job_central), .job_radius(job_radius),
    .job_mode(job_mode),
    .set_en(set_en), .set_central(set_central),
    .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid),
    .set_cand(set_cand),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .done_cnt(done_cnt)
  );

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_circ(input int cx, input int cy,
                                 input int r, input int x,
                                 input int y);
    return (x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r;
  endfunction

  // Lattice points of the 8x8 grid (1..8) covered per mode rule.
  function automatic logic [7:0] ref_cand(input logic [23:0] c,
                                          input logic [11:0] r,
                                          input logic [1:0] m);
    int n = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        bit a, b, k;
        a = in_circ(int'(c[23:20]), int'(c[19:16]), int'(r[11:8]), x, y);
        b = in_circ(int'(c[15:12]), int'(c[11:8]), int'(r[7:4]), x, y);
        k = in_circ(int'(c[7:4]), int'(c[3:0]), int'(r[3:0]), x, y);
        case (m)
          2'b00: n += int'(a);
          2'b01: n += int'(a & b);
          2'b10: n += int'(a ^ b);
          default: n += int'((int'(a) + int'(b) + int'(k)) == 2);
        endcase
      end
    end
    return 8'(n);
  endfunction

  // Behavioural SET: busy after en, 64 busy cycles, 1-cycle valid.
  // Reset only at time zero so it keeps running across issuer resets.
  logic        m_rst;
  logic        m_busy;
  logic        m_valid;
  logic [7:0]  m_cand;
  int          m_left;
  bit          m_mute;
  bit          m_moved;
  logic [37:0] m_snap;
  logic        stray;

  assign set_busy  = m_busy;
  assign set_valid = m_valid | stray;
  assign set_cand  = stray ? 8'hAA : m_cand;

  always @(posedge clk) begin
    if (m_rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cand  <= '0;
      m_left  <= 0;
      m_moved <= 1'b0;
      m_snap  <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy) begin
        if ({set_central, set_radius, set_mode} != m_snap)
          m_moved <= 1'b1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_valid <= !m_mute;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (set_en) begin
        m_busy  <= 1'b1;
        m_left  <= SET_LAT - 1;
        m_snap  <= {set_central, set_radius, set_mode};
        m_cand  <= ref_cand(set_central, set_radius, set_mode);
        m_moved <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr_mode == 0) res_ready = 1'b1;
    else if (rr_mode == 1) res_ready = ($urandom % 3) != 0;
  end

  // Monitor: independent of the driver, pops the scoreboard.
  bit         outstanding = 0;
  int         acc_cyc     = 0;
  bit         prev_rv     = 0;
  logic [7:0] prev_rd     = '0;
  logic       prev_re     = 1'b0;
  bit         prev_hs     = 0;
  bit         done_pend   = 0;
  int         exp_done    = 0;
  int         en_len      = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_rv     = 0;
      prev_hs     = 0;
      done_pend   = 0;
      exp_done    = 0;
      en_len      = 0;
      sb.delete();
    end else begin
      if (done_pend) begin
        chk(done_cnt == CNT_W'(exp_done), "done_cnt",
            done_cnt, exp_done);
        done_pend = 0;
      end
      chk(job_ready == (!outstanding && !set_busy), "job_ready",
          job_ready, !outstanding && !set_busy);
      if (set_en) begin
        en_len++;
      end else if (en_len != 0) begin
        chk(en_len == 1, "set_en_width", en_len, 1);
        en_len = 0;
      end
      if (m_valid && outstanding)
        chk(!m_moved, "set_stable", m_moved, 0);
      if (res_valid && !prev_rv && sb.size() != 0)
        chk(cyc - acc_cyc == sb[0].lat, "latency",
            cyc - acc_cyc, sb[0].lat);
      if (res_valid && prev_rv && !prev_hs)
        chk(res_data == prev_rd && res_err == prev_re, "res_hold",
            {res_err, res_data}, {prev_re, prev_rd});
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk(0, "unexpected_result", res_data, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(res_data == e.d, "res_data", res_data, e.d);
          chk(res_err == e.e, "res_err", res_err, e.e);
        end
        exp_done++;
        done_pend   = 1;
        outstanding = 0;
      end
      if (job_valid && job_ready) begin
        outstanding = 1;
        acc_cyc     = cyc;
      end
      prev_rv = res_valid;
      prev_rd = res_data;
      prev_re = res_err;
      prev_hs = res_valid && res_ready;
    end
  end

  task automatic send_job(input logic [23:0] c, input logic [11:0] r,
                          input logic [1:0] m, input logic [7:0] d,
                          input bit e, input int lat);
    job_central = c;
    job_radius  = r;
    job_mode    = m;
    job_valid   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (job_ready) begin
        sb.push_back('{d, e, lat});
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk(0, "accept_timeout", 0, 1);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk(0, "result_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({set_en, res_valid, res_err, res_data, done_cnt} == '0,
        nm, {set_en, res_valid, res_err, res_data, done_cnt}, 0);
    chk({set_central, set_radius, set_mode} == '0,
        {nm, "_set"}, {set_central, set_radius, set_mode}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  localparam logic [23:0] C_A   = 24'h440000;
  localparam logic [23:0] C_AB  = 24'h444400;
  localparam logic [23:0] C_ABC = 24'h444411;
  localparam logic [11:0] R_A   = 12'h200;
  localparam logic [11:0] R_AB  = 12'h220;

  initial begin
    rst_n       = 1'b0;
    m_rst       = 1'b1;
    m_mute      = 0;
    stray       = 1'b0;
    job_valid   = 1'b0;
    job_central = '0;
    job_radius  = '0;
    job_mode    = '0;
    res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_rst  = 1'b0;
    rr_mode = 0;

    send_job(C_A, R_A, 2'b00, 8'd13, 0, SET_LAT + 2);
    wait_idle(300);
    @(negedge clk);
    chk(done_cnt == 1, "done_after_1", done_cnt, 1);
    @(posedge clk);
    #1;

    send_job(C_AB, R_AB, 2'b01, 8'd13, 0, SET_LAT + 2);
    send_job(C_AB, R_AB, 2'b10, 8'd0, 0, SET_LAT + 2);
    wait_idle(300);
    @(negedge clk);
    chk(done_cnt == 3, "done_after_3", done_cnt, 3);
    @(posedge clk);
    #1;

    send_job(C_ABC, R_AB, 2'b11, 8'd13, 0, SET_LAT + 2);
    wait_idle(300);

    rr_mode   = 2;
    res_ready = 1'b0;
    send_job(C_A, R_A, 2'b00, 8'd13, 0, SET_LAT + 2);
    for (int i = 0; i < 300 && !res_valid; i++) @(negedge clk);
    chk(res_valid, "stall_res_valid", res_valid, 1);
    @(posedge clk);
    #1;
    job_central = C_AB;
    job_radius  = R_AB;
    job_mode    = 2'b01;
    job_valid   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      stray = (k == 3);
      @(negedge clk);
      chk(!job_ready, "stall_no_accept", job_ready, 0);
      chk(res_data == 8'd13, "stall_data", res_data, 13);
      @(posedge clk);
      #1;
    end
    stray     = 1'b0;
    job_valid = 1'b0;
    rr_mode   = 0;
    res_ready = 1'b1;
    wait_idle(300);

    rr_mode = 1;
    for (int j = 0; j < 20; j++) begin
      logic [23:0] c;
      logic [11:0] r;
      logic [1:0]  m;
      c = 24'($urandom());
      r = 12'($urandom());
      m = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_job(c, r, m, ref_cand(c, r, m), 0, SET_LAT + 2);
    end
    wait_idle(400);

`ifdef SET_TIMEOUT_EN
    rr_mode = 0;
    m_mute  = 1;
    send_job(C_A, R_A, 2'b00, 8'd0, 1, TIMEOUT + 2);
    wait_idle(300);
    m_mute  = 0;
    repeat (5) @(posedge clk);
    #1;
`endif

    rr_mode = 0;
    send_job(C_A, R_A, 2'b00, 8'd13, 0, SET_LAT + 2);
    repeat (20) @(posedge clk);
    #1;
    rst_n       = 1'b0;
    job_valid   = 1'b1;
    job_central = C_AB;
    job_radius  = R_AB;
    job_mode    = 2'b10;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_job(C_AB, R_AB, 2'b10, 8'd0, 0, SET_LAT + 2);
    wait_idle(400);
    @(negedge clk);
    chk(done_cnt == 1, "done_after_reset", done_cnt, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
